// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

    localparam int DEF_ITERS = 32;
    localparam int DEF_WIDTH = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Divide ops have op[1] set; the unsigned variants have op[0] set.
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of unsigned shift-add multiply or restoring divide.
// Multiply: acc = {partial product high, remaining multiplier bits}.
// Divide:   acc = {partial remainder, remaining dividend / quotient bits}.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               is_div,
    output logic [2*WIDTH-1:0] acc_nxt
);

    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;

    // Compute both candidate updates and select by operation class.
    always_comb begin
        acc_hi = acc[2*WIDTH-1:WIDTH];
        acc_lo = acc[WIDTH-1:0];
        // Multiply: conditionally add, keep the carry, then shift right.
        sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
        // Divide: shift the next dividend bit into the remainder.
        rem_sh = {acc_hi, acc_lo[WIDTH-1]};
        // When the subtraction is kept the result is below the divisor,
        // so the low WIDTH bits hold it exactly.
        diff   = rem_sh[WIDTH-1:0] - operand;
        if (is_div) begin
            if (rem_sh >= {1'b0, operand}) begin
                acc_nxt = {diff, acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt = {rem_sh[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_nxt = {sum, acc_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/hilo_muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU controller owning the HI/LO pair and
// the pipeline stall for dependent instructions.
module hilo_muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int ITERS = DEF_ITERS,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             read_hilo,
    input  logic             mthi_we,
    input  logic             mtlo_we,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic             stall_out
);

    localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               is_div_r;
    logic               neg_res_r;
    logic               neg_rem_r;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   rs_raw;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;
    logic               done_r;
    logic               div0_r;
    logic               op_signed;

    // Magnitude of a two's-complement value; the most negative value maps
    // to itself, which as an unsigned magnitude is the correct 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] x,
                                                   input logic use_sign);
        return (use_sign && (x < 0)) ? -x : x;
    endfunction

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x,
                                                  input logic neg);
        return neg ? -x : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] x,
                                                     input logic neg);
        return neg ? -x : x;
    endfunction

    assign op_signed = op_is_signed(op);

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc     (acc),
        .operand (b_mag),
        .is_div  (is_div_r),
        .acc_nxt (acc_nxt)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: capture, iterate ITERS times, one fixup edge.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (cnt == CNT_W'(ITERS - 1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Iteration counter and the registered completion flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            done_r <= 1'b0;
            div0_r <= 1'b0;
        end else begin
            done_r <= (state == FIX);
            div0_r <= (state == FIX) && is_div_r && (b_mag == '0);
            if (state == CALC) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                cnt <= '0;
            end
        end
    end

    // Operand capture in IDLE and accumulator update during CALC; frozen otherwise.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            is_div_r  <= op_is_div(op);
            neg_res_r <= op_signed & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
            neg_rem_r <= op_signed & rs_val[WIDTH-1];
            b_mag     <= magnitude(rt_val, op_signed);
            rs_raw    <= rs_val;
            acc       <= {{WIDTH{1'b0}}, magnitude(rs_val, op_signed)};
        end else if (state == CALC) begin
            acc <= acc_nxt;
        end
    end

    // Sign fixup of the unsigned result; divide-by-zero yields all-ones / dividend.
    always_comb begin
        fix_hi = '0;
        fix_lo = '0;
        if (is_div_r) begin
            if (b_mag == '0) begin
                fix_lo = '1;
                fix_hi = rs_raw;
            end else begin
                fix_lo = cond_neg(acc[WIDTH-1:0], neg_res_r);
                fix_hi = cond_neg(acc[2*WIDTH-1:WIDTH], neg_rem_r);
            end
        end else begin
            {fix_hi, fix_lo} = cond_neg2(acc, neg_res_r);
        end
    end

    // HI/LO: result write on the fixup edge, MTHI/MTLO only while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_r <= '0;
            lo_r <= '0;
        end else if (state == FIX) begin
            hi_r <= fix_hi;
            lo_r <= fix_lo;
        end else if (state == IDLE) begin
            if (mthi_we) hi_r <= wr_data;
            if (mtlo_we) lo_r <= wr_data;
        end
    end

    assign hi_out    = hi_r;
    assign lo_out    = lo_r;
    assign done      = done_r;
    assign div0      = div0_r;
    assign busy      = (state != IDLE);
    assign stall_out = busy & (start | read_hilo | mthi_we | mtlo_we);

endmodule

// File: doc/hilo_muldiv_sequencer.md
Name: hilo_muldiv_sequencer

Overview:
- Multi-cycle controller for MULT/MULTU/DIV/DIVU and the HI/LO register pair, sitting alongside the EX stage.
- Accepts an operation from ID/EX, then runs an iterative shift-add multiply or restoring divide.
- Writes HI/LO on completion and drives the pipeline stall (PC/NPC/IF_ID load-enable hold) while the unit is busy and a dependent instruction tries to issue.

Parameters:
- ITERS, 32, iteration count; equals the operand width.
- WIDTH, 32, operand, HI and LO width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  ID/EX holds a mult/div instruction this cycle
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- rs_val  in  WIDTH  operand A: multiplicand or dividend
- rt_val  in  WIDTH  operand B: multiplier or divisor
- read_hilo  in  1  ID/EX holds MFHI/MFLO
- mthi_we  in  1  ID/EX holds MTHI
- mtlo_we  in  1  ID/EX holds MTLO
- wr_data  in  WIDTH  data for MTHI/MTLO
- hi_out  out  WIDTH  HI register
- lo_out  out  WIDTH  LO register
- busy  out  1  sequencer not idle
- done  out  1  one-cycle pulse: HI/LO just updated by mult/div
- div0  out  1  pulses with done when the divisor was zero
- stall_out  out  1  hold PC, NPC and IF_ID; inject NOP into ID/EX

Behaviour:
- Reset (synchronous, takes priority over all else): state IDLE; HI=0, LO=0; busy=0, done=0, div0=0, stall_out=0. Reset mid-operation aborts without writing HI/LO.
- States:
  - IDLE: start=1 at an edge captures op, |rs|, |rt|, the sign flags and the raw rs; go to CALC with cnt=0.
  - CALC: one iteration per edge. Multiply: add-shift on a 2*WIDTH accumulator. Divide: restoring shift-subtract on a remainder/quotient pair. At the edge where cnt==ITERS-1, go to FIX.
  - FIX: one edge. Apply sign fixup, write HI/LO, return to IDLE.
- Registered flags: done=1 and div0 (if applicable) in the cycle after the FIX edge.
- Latency: start sampled at edge 0 → HI/LO updated at edge ITERS+1 (edge 33) → done high during the following cycle.
- busy = (state != IDLE), combinational from state.
- Sign rules:
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Unsigned ops use raw operands.
- Width rules: all arithmetic is modulo 2^WIDTH per half. DIV 0x80000000 / -1 → LO=0x80000000, HI=0 (natural wrap, no trap).
- Divide by zero: no early exit; same latency. LO=0xFFFFFFFF, HI=raw rs_val, div0 pulses with done.
- stall_out = busy & (start | read_hilo | mthi_we | mtlo_we), combinational.
  - A start while busy is ignored; the stall holds the instruction until IDLE.
  - In IDLE, stall_out is always 0.
- MFHI/MFLO in IDLE read hi_out/lo_out directly, with no stall.
- MTHI/MTLO in IDLE write HI/LO at the edge. If start fires in the same cycle, the mt write lands now and the mult/div result overwrites both registers at completion.
- The FIX-edge write and the done pulse never coincide with an mt write: mt writes are stalled while busy.
- Operand registers are frozen during CALC; input changes are ignored.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU
  - state enum IDLE/CALC/FIX
  - default ITERS/WIDTH constants
- Sub-module muldiv_step: combinational single iteration, taking accumulator/remainder, operand and op class and producing the next value. The sequencer owns the FSM, counter, fixup, HI/LO and stall logic.

Test Plan:
- MULT rs=7, rt=0xFFFFFFFD (-3) → after edge 33: HI=0xFFFFFFFF, LO=0xFFFFFFEB; done high exactly one cycle; busy high for 33 cycles.
- MULTU rs=rt=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV rs=0xFFFFFFF9 (-7), rt=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU rs=100, rt=7 → LO=14, HI=2.
- DIVU rs=0x1234, rt=0 → LO=0xFFFFFFFF, HI=0x1234, div0 and done pulse together at the same latency.
- Hazards: read_hilo=1 at cycle 5 after start → stall_out=1 through the last busy cycle, 0 once IDLE; a second start during busy is not captured, and a first result of 6*7 gives LO=42.
- Reset and mt writes: reset asserted at cycle 10 of CALC → next cycle busy=0, HI=LO=0, no done pulse. Then MTLO 0xABCD in IDLE → lo_out=0xABCD one edge later, stall_out stays 0.
